vga_pattern_gen: RTL and testbench

- Parametrised RGB565 test-pattern generator; successor to the single-mode column-bar generator.
- Sits between vga_sync and the DAC/RGB pins.
- Produces four run-time selectable patterns: vertical bars, horizontal bars, checkerboard, and solid colour.
- Column and row indices come from incremental counters, not modulo arithmetic. RGB output is registered, and a delayed video_on is provided for alignment.

---
 rtl/vga_pattern_gen.sv | 138 +++++++++++++
 tb/tb_vga_pattern_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// RGB565 test-pattern generator: vertical bars, horizontal bars, checkerboard or solid colour.
// Bar position comes from incremental pixel/line counters; the RGB output is registered one clock after video_on.
module vga_pattern_gen #(
    parameter int H_PIXELS          = 800,
    parameter int V_PIXELS          = 600,
    parameter int NUMBER_OF_COLUMNS = 8,
    parameter int NUMBER_OF_ROWS    = 8,
    parameter int PIXEL_GEN_BITS    = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PIXEL_GEN_BITS-1:0] pixel_x,
    input  logic                      video_on,
    input  logic                      frame_start,
    input  logic [1:0]                mode,
    input  logic [15:0]               solid_rgb,
    output logic [4:0]                RED_OUT,
    output logic [5:0]                GREEN_OUT,
    output logic [4:0]                BLUE_OUT,
    output logic                      video_on_out
);

    localparam int CW    = PIXEL_GEN_BITS;
    localparam int COL_W = H_PIXELS / NUMBER_OF_COLUMNS;
    localparam int ROW_H = V_PIXELS / NUMBER_OF_ROWS;

    localparam logic [CW-1:0] COL_CNT_LAST = CW'(COL_W - 1);
    localparam logic [CW-1:0] COL_IDX_LAST = CW'(NUMBER_OF_COLUMNS - 1);
    localparam logic [CW-1:0] ROW_CNT_LAST = CW'(ROW_H - 1);
    localparam logic [CW-1:0] ROW_IDX_LAST = CW'(NUMBER_OF_ROWS - 1);

    localparam logic [1:0] MODE_VBARS   = 2'd0;
    localparam logic [1:0] MODE_HBARS   = 2'd1;
    localparam logic [1:0] MODE_CHECKER = 2'd2;

    logic [CW-1:0] col_cnt_q, col_cnt_d;
    logic [CW-1:0] col_idx_q, col_idx_d;
    logic [CW-1:0] row_cnt_q, row_cnt_d;
    logic [CW-1:0] row_idx_q, row_idx_d;
    logic [1:0]    mode_lat_q, mode_lat_d;
    logic [15:0]   solid_lat_q, solid_lat_d;
    logic [15:0]   rgb_q, rgb_d;
    logic          video_on_q, video_on_d;
    logic [15:0]   colour;
    logic          line_end;

    // Bar timing is purely counter based; pixel_x is accepted only for pin compatibility.
    logic unused_pixel_x;
    assign unused_pixel_x = ^pixel_x;

    function automatic logic [15:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    palette = 16'hFFFF;
            3'd1:    palette = 16'hFFE0;
            3'd2:    palette = 16'h07FF;
            3'd3:    palette = 16'h07E0;
            3'd4:    palette = 16'hF81F;
            3'd5:    palette = 16'hF800;
            3'd6:    palette = 16'h001F;
            default: palette = 16'h0000;
        endcase
    endfunction

    assign line_end = video_on_q & ~video_on;

    always_comb begin
        col_cnt_d = '0;
        col_idx_d = '0;
        if (video_on) begin
            if (col_cnt_q == COL_CNT_LAST) begin
                col_idx_d = (col_idx_q == COL_IDX_LAST) ? col_idx_q : col_idx_q + 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
                col_idx_d = col_idx_q;
            end
        end
    end

    always_comb begin
        row_cnt_d = row_cnt_q;
        row_idx_d = row_idx_q;
        if (frame_start) begin
            row_cnt_d = '0;
            row_idx_d = '0;
        end else if (line_end) begin
            if (row_cnt_q == ROW_CNT_LAST) begin
                row_cnt_d = '0;
                row_idx_d = (row_idx_q == ROW_IDX_LAST) ? row_idx_q : row_idx_q + 1'b1;
            end else begin
                row_cnt_d = row_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        mode_lat_d  = frame_start ? mode      : mode_lat_q;
        solid_lat_d = frame_start ? solid_rgb : solid_lat_q;
    end

    always_comb begin
        case (mode_lat_q)
            MODE_VBARS:   colour = palette(col_idx_q[2:0]);
            MODE_HBARS:   colour = palette(row_idx_q[2:0]);
            MODE_CHECKER: colour = (col_idx_q[0] ^ row_idx_q[0]) ? 16'h0000 : 16'hFFFF;
            default:      colour = solid_lat_q;
        endcase
        rgb_d      = video_on ? colour : 16'h0000;
        video_on_d = video_on;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_q   <= '0;
            col_idx_q   <= '0;
            row_cnt_q   <= '0;
            row_idx_q   <= '0;
            mode_lat_q  <= 2'd0;
            solid_lat_q <= 16'h0000;
            rgb_q       <= 16'h0000;
            video_on_q  <= 1'b0;
        end else begin
            col_cnt_q   <= col_cnt_d;
            col_idx_q   <= col_idx_d;
            row_cnt_q   <= row_cnt_d;
            row_idx_q   <= row_idx_d;
            mode_lat_q  <= mode_lat_d;
            solid_lat_q <= solid_lat_d;
            rgb_q       <= rgb_d;
            video_on_q  <= video_on_d;
        end
    end

    assign RED_OUT      = rgb_q[15:11];
    assign GREEN_OUT    = rgb_q[10:5];
    assign BLUE_OUT     = rgb_q[4:0];
    assign video_on_out = video_on_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: default 8x8 geometry plus a 3-column instance sharing the same stimulus.
module tb_vga_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] pixel_x = '0;
    logic        video_on = 1'b0;
    logic        frame_start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] solid_rgb = 16'h0000;

    logic [4:0]  red8, red3;
    logic [5:0]  green8, green3;
    logic [4:0]  blue8, blue3;
    logic        vo8, vo3;
    logic [15:0] rgb8, rgb3;

    int n_checks = 0;
    int n_fail   = 0;

    // Palette constants written out by hand.
    logic [15:0] pal [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    always #5 clk = ~clk;

    vga_pattern_gen dut8 (
        .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .video_on(video_on),
        .frame_start(frame_start), .mode(mode), .solid_rgb(solid_rgb),
        .RED_OUT(red8), .GREEN_OUT(green8), .BLUE_OUT(blue8), .video_on_out(vo8)
    );

    vga_pattern_gen #(.NUMBER_OF_COLUMNS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .video_on(video_on),
        .frame_start(frame_start), .mode(mode), .solid_rgb(solid_rgb),
        .RED_OUT(red3), .GREEN_OUT(green3), .BLUE_OUT(blue3), .video_on_out(vo3)
    );

    assign rgb8 = {red8, green8, blue8};
    assign rgb3 = {red3, green3, blue3};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_rgb(input logic [1:0] m, input logic [15:0] s,
                                            input int p, input int row);
        int c, r;
        c = (p / 100 > 7) ? 7 : p / 100;
        r = (row / 75 > 7) ? 7 : row / 75;
        case (m)
            2'd0:    exp_rgb = pal[c];
            2'd1:    exp_rgb = pal[r];
            2'd2:    exp_rgb = (((c ^ r) & 1) != 0) ? 16'h0000 : 16'hFFFF;
            default: exp_rgb = s;
        endcase
    endfunction

    function automatic logic [15:0] exp_rgb3(input int p);
        if (p < 266)      exp_rgb3 = pal[0];
        else if (p < 532) exp_rgb3 = pal[1];
        else              exp_rgb3 = pal[2];
    endfunction

    // Drives one active line of len pixels followed by blanking; expectations use the latched mode m / colour s.
    task automatic drive_line(input int len, input logic [1:0] m, input logic [15:0] s,
                              input int row, input bit chk);
        int p;
        for (int k = 0; k <= len; k++) begin
            @(negedge clk);
            p = k - 1;
            if (chk && k > 0 && ((p % 100) == 0 || (p % 100) == 99 || p == len - 1)) begin
                check($sformatf("rgb m%0d row%0d px%0d", m, row, p), rgb8, exp_rgb(m, s, p, row));
                check($sformatf("vo_out row%0d px%0d", row, p), {15'd0, vo8}, 16'd1);
            end
            if (chk && k > 0 && m == 2'd0 && len == 800 &&
                (p == 0 || p == 265 || p == 266 || p == 531 || p == 532 || p == 799))
                check($sformatf("rgb3col row%0d px%0d", row, p), rgb3, exp_rgb3(p));
            video_on = (k < len);
            pixel_x  = 12'(k);
        end
        @(negedge clk);
        if (chk) begin
            check($sformatf("blank rgb row%0d", row), rgb8, 16'h0000);
            check($sformatf("blank vo_out row%0d", row), {15'd0, vo8}, 16'd0);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic frame(input logic [1:0] m, input logic [15:0] s);
        @(negedge clk);
        video_on    = 1'b0;
        frame_start = 1'b1;
        mode        = m;
        solid_rgb   = s;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset held with video active: outputs must stay zero.
        rst_n    = 1'b0;
        video_on = 1'b1;
        repeat (4) @(negedge clk);
        check("reset rgb", rgb8, 16'h0000);
        check("reset vo_out", {15'd0, vo8}, 16'd0);
        video_on = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // No frame_start yet: default mode 0 bars.
        drive_line(800, 2'd0, 16'h0000, 0, 1'b1);

        // Mode 0 after an explicit frame_start.
        frame(2'd0, 16'h0000);
        drive_line(800, 2'd0, 16'h0000, 0, 1'b1);

        // Mode 1: short lines are enough since rows only count line ends.
        frame(2'd1, 16'h0000);
        for (int r = 0; r < 600; r++)
            drive_line(4, 2'd1, 16'h0000, r,
                       (r == 0 || r == 74 || r == 75 || r == 149 || r == 525 || r == 599));

        // Mode 2 checkerboard: full lines 0 and 75, short lines between.
        frame(2'd2, 16'h0000);
        drive_line(800, 2'd2, 16'h0000, 0, 1'b1);
        for (int r = 1; r < 75; r++)
            drive_line(4, 2'd2, 16'h0000, r, 1'b0);
        drive_line(800, 2'd2, 16'h0000, 75, 1'b1);

        // Solid colour latched; mid-frame changes to mode/solid_rgb must be ignored.
        frame(2'd3, 16'h1234);
        mode      = 2'd0;
        solid_rgb = 16'hABCD;
        drive_line(800, 2'd3, 16'h1234, 0, 1'b1);
        for (int r = 1; r < 80; r++)
            drive_line(4, 2'd3, 16'h1234, r, (r == 79));
        drive_line(800, 2'd3, 16'h1234, 80, 1'b1);

        frame(2'd0, 16'hABCD);
        drive_line(800, 2'd0, 16'hABCD, 0, 1'b1);

        // Asynchronous reset in the middle of a solid-colour line.
        frame(2'd3, 16'h5A5A);
        @(negedge clk);
        video_on = 1'b1;
        repeat (5) @(negedge clk);
        check("pre-reset solid", rgb8, 16'h5A5A);
        #2 rst_n = 1'b0;
        #1;
        check("async reset rgb", rgb8, 16'h0000);
        check("async reset vo_out", {15'd0, vo8}, 16'd0);
        @(negedge clk);
        video_on = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        drive_line(800, 2'd0, 16'h0000, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
